// File: rtl/unidade_controle_geogenius.sv
// Quiz sequencer for the GeoGenius datapath: a Moore FSM that drives the counters, LEDs and answer register.
// State outputs are registered next to the state. Only the PROXIMA advance pulse also depends on ultima_jogada.
module unidade_controle_geogenius #(
   parameter logic TIMEOUT_ENCERRA = 1'b1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       iniciar,
   input  logic       dificuldade_chave,
   input  logic       fez_jogada,
   input  logic       jogada_igual_memoria,
   input  logic       ultima_jogada,
   input  logic       deu_timeout,
   input  logic       fim_timer_resultado,
   output logic       zera_contador_jogada,
   output logic       zera_contador_score,
   output logic       zera_timer_resultado,
   output logic       zera_timeout,
   output logic       zeraR,
   output logic       zera_tempo_de_jogo,
   output logic       conta_score,
   output logic       conta_jogada,
   output logic       conta_timer_resultado,
   output logic       conta_timeout,
   output logic       registraR,
   output logic       liga_led,
   output logic       mostra_tempo_de_jogo,
   output logic       dificuldade,
   output logic       led_acerto,
   output logic       led_erro,
   output logic       pronto,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL      = 4'd0,
      PREPARA      = 4'd1,
      CARREGA      = 4'd2,
      ESPERA       = 4'd3,
      REGISTRA     = 4'd4,
      COMPARA      = 4'd5,
      ACERTOU      = 4'd6,
      EXIBE_ACERTO = 4'd7,
      EXIBE_ERRO   = 4'd8,
      PROXIMA      = 4'd9,
      FIM_JOGO     = 4'd10,
      FIM_TIMEOUT  = 4'd11
   } estado_t;

   typedef struct packed {
      logic zera_contador_jogada;
      logic zera_contador_score;
      logic zera_timer_resultado;
      logic zera_timeout;
      logic zera_reg;
      logic zera_tempo_de_jogo;
      logic conta_score;
      logic conta_timer_resultado;
      logic conta_timeout;
      logic registra_reg;
      logic liga_led;
      logic mostra_tempo_de_jogo;
      logic led_acerto;
      logic led_erro;
      logic pronto;
   } saidas_t;

   estado_t estado_r;
   estado_t prox_s;
   saidas_t saidas_r;
   logic    dificuldade_r;
   logic    avanca_s;

   // Output pattern of each state. The registered copy is loaded from the next state.
   function automatic saidas_t decodifica(input estado_t e);
      saidas_t s;
      s = '0;
      case (e)
         PREPARA: begin
            s.zera_contador_jogada = 1'b1;
            s.zera_contador_score  = 1'b1;
            s.zera_timer_resultado = 1'b1;
            s.zera_timeout         = 1'b1;
            s.zera_reg             = 1'b1;
            s.zera_tempo_de_jogo   = 1'b1;
         end
         CARREGA: begin
            s.zera_timeout         = 1'b1;
            s.zera_timer_resultado = 1'b1;
         end
         ESPERA: begin
            s.liga_led             = 1'b1;
            s.conta_timeout        = 1'b1;
            s.zera_timer_resultado = 1'b1;
         end
         REGISTRA: begin
            s.registra_reg = 1'b1;
            s.liga_led     = 1'b1;
         end
         COMPARA:  s.liga_led    = 1'b1;
         ACERTOU:  s.conta_score = 1'b1;
         EXIBE_ACERTO: begin
            s.led_acerto            = 1'b1;
            s.conta_timer_resultado = 1'b1;
         end
         EXIBE_ERRO: begin
            s.led_erro              = 1'b1;
            s.conta_timer_resultado = 1'b1;
         end
         FIM_JOGO: begin
            s.pronto               = 1'b1;
            s.mostra_tempo_de_jogo = 1'b1;
         end
         FIM_TIMEOUT: begin
            s.pronto               = 1'b1;
            s.mostra_tempo_de_jogo = 1'b1;
            s.led_erro             = 1'b1;
         end
         default: s = '0;
      endcase
      return s;
   endfunction

   // Next-state selection; fez_jogada takes priority over a simultaneous timeout
   always_comb begin
      prox_s = estado_r;
      case (estado_r)
         INICIAL: begin
            if (iniciar) prox_s = PREPARA;
            else         prox_s = INICIAL;
         end
         PREPARA:  prox_s = CARREGA;
         CARREGA:  prox_s = ESPERA;
         ESPERA: begin
            if (fez_jogada)       prox_s = REGISTRA;
            else if (deu_timeout) prox_s = TIMEOUT_ENCERRA ? FIM_TIMEOUT : EXIBE_ERRO;
            else                  prox_s = ESPERA;
         end
         REGISTRA: prox_s = COMPARA;
         COMPARA: begin
            if (jogada_igual_memoria) prox_s = ACERTOU;
            else                      prox_s = EXIBE_ERRO;
         end
         ACERTOU:  prox_s = EXIBE_ACERTO;
         EXIBE_ACERTO, EXIBE_ERRO: begin
            if (fim_timer_resultado) prox_s = PROXIMA;
            else                     prox_s = estado_r;
         end
         PROXIMA: begin
            if (ultima_jogada) prox_s = FIM_JOGO;
            else               prox_s = CARREGA;
         end
         FIM_JOGO, FIM_TIMEOUT: begin
            if (iniciar) prox_s = PREPARA;
            else         prox_s = estado_r;
         end
         default:  prox_s = INICIAL;
      endcase
   end

   // State, registered outputs and the difficulty latched while in PREPARA
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_r      <= INICIAL;
         saidas_r      <= '0;
         dificuldade_r <= 1'b0;
      end else begin
         estado_r <= prox_s;
         saidas_r <= decodifica(prox_s);
         if (estado_r == PREPARA) dificuldade_r <= dificuldade_chave;
         else                     dificuldade_r <= dificuldade_r;
      end
   end

   // Advancing to the next question is the only output that depends on an input as well as the state.
   assign avanca_s = (estado_r == PROXIMA) && !ultima_jogada;

   assign zera_contador_jogada  = saidas_r.zera_contador_jogada;
   assign zera_contador_score   = saidas_r.zera_contador_score;
   assign zera_timer_resultado  = saidas_r.zera_timer_resultado;
   assign zera_timeout          = saidas_r.zera_timeout;
   assign zeraR                 = saidas_r.zera_reg | avanca_s;
   assign zera_tempo_de_jogo    = saidas_r.zera_tempo_de_jogo;
   assign conta_score           = saidas_r.conta_score;
   assign conta_jogada          = avanca_s;
   assign conta_timer_resultado = saidas_r.conta_timer_resultado;
   assign conta_timeout         = saidas_r.conta_timeout;
   assign registraR             = saidas_r.registra_reg;
   assign liga_led              = saidas_r.liga_led;
   assign mostra_tempo_de_jogo  = saidas_r.mostra_tempo_de_jogo;
   assign dificuldade           = dificuldade_r;
   assign led_acerto            = saidas_r.led_acerto;
   assign led_erro              = saidas_r.led_erro;
   assign pronto                = saidas_r.pronto;
   assign db_estado             = estado_r;

endmodule
